rotator_sched: RTL

- Scheduler that shares one 100-bit left/right rotator datapath between two requesters.
- Each requester submits a command: data word, direction and rotation amount, over a valid/ready handshake.
- The block arbitrates round-robin, loads the rotator, drives its enable for the minimum number of cycles, then returns the rotated word with the requester ID over a valid/ready response channel.
- It sits between the command sources and the rotator instance. It drives the rotator's load/ena/data ports and observes its q output.

---
 rtl/rotator_pkg.sv | 16 +
 rtl/rotator.sv | 26 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/rotator_sched.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rotator_pkg.sv
// rtl/rotator_pkg.sv - shared constants for the rotator scheduler slice
package rotator_pkg;

  localparam int WIDTH_DEF = 100;
  localparam int AMT_W_DEF = 7;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ROT  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [1:0] ENA_HOLD  = 2'b00;
  localparam logic [1:0] ENA_RIGHT = 2'b01;
  localparam logic [1:0] ENA_LEFT  = 2'b10;

endpackage

// File: rtl/rotator.sv
// rtl/rotator.sv - loadable left/right rotate-by-one register
module rotator
  import rotator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             load,
  input  logic [1:0]       ena,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (load) begin
      q <= data;
    end else begin
      case (ena)
        ENA_RIGHT: q <= {q[0], q[WIDTH-1:1]};
        ENA_LEFT:  q <= {q[WIDTH-2:0], q[WIDTH-1]};
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin arbiter with last-grant memory
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] ready,
  output logic       gnt_id,
  output logic       gnt_valid
);

  logic last_grant;

  always_comb begin
    gnt_valid = en & (|req);
    gnt_id    = (req == 2'b11) ? ~last_grant : req[1];
    ready     = 2'b00;
    if (gnt_valid) begin
      ready = gnt_id ? 2'b10 : 2'b01;
    end
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (gnt_valid) begin
      last_grant <= gnt_id;
    end
  end

endmodule

// File: rtl/rotator_sched.sv
// rtl/rotator_sched.sv - shares one rotator between two requesters, round-robin
module rotator_sched
  import rotator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req0_dir,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic             req1_dir,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy,
  output logic             rot_load,
  output logic [1:0]       rot_ena,
  output logic [WIDTH-1:0] rot_data,
  input  logic [WIDTH-1:0] rot_q
);

  localparam logic [AMT_W-1:0] W_AMT    = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] HALF_AMT = AMT_W'(WIDTH / 2);
  localparam logic [AMT_W-1:0] ONE_AMT  = AMT_W'(1);

  logic [1:0]       state;
  logic [AMT_W-1:0] cnt;
  logic             dir_q;
  logic             id_q;
  logic [WIDTH-1:0] data_q;

  logic [1:0]       req_ready;
  logic             gnt_id;
  logic             gnt_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic [AMT_W-1:0] in_amt;
  logic [AMT_W-1:0] k_mod;
  logic [AMT_W-1:0] k_eff;
  logic             dir_eff;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state == IDLE),
    .req       ({req1_valid, req0_valid}),
    .ready     (req_ready),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  // Rotating more than half-way is done the short way round in the other direction.
  always_comb begin
    in_data = gnt_id ? req1_data : req0_data;
    in_dir  = gnt_id ? req1_dir  : req0_dir;
    in_amt  = gnt_id ? req1_amt  : req0_amt;
    k_mod   = (in_amt >= W_AMT) ? (in_amt - W_AMT) : in_amt;
    k_eff   = k_mod;
    dir_eff = in_dir;
    if (k_mod > HALF_AMT) begin
      k_eff   = W_AMT - k_mod;
      dir_eff = ~in_dir;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      dir_q  <= 1'b0;
      id_q   <= 1'b0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            data_q <= in_data;
            id_q   <= gnt_id;
            dir_q  <= dir_eff;
            cnt    <= k_eff;
            state  <= LOAD;
          end
        end
        LOAD: state <= (cnt != '0) ? ROT : RESP;
        ROT: begin
          cnt <= cnt - ONE_AMT;
          if (cnt == ONE_AMT) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign busy       = (state != IDLE);
  assign rot_load   = (state == LOAD);
  assign rot_ena    = (state == ROT) ? (dir_q ? ENA_LEFT : ENA_RIGHT) : ENA_HOLD;
  assign rot_data   = data_q;
  assign rsp_valid  = (state == RESP);
  assign rsp_data   = rot_q;
  assign rsp_id     = id_q;

endmodule
